multiplicador_algoritmico: RTL and testbench

MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

---
 rtl/multiplicador_algoritmico.sv | 78 +++++++
 tb/tb_multiplicador_algoritmico.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico: shift-and-add Num = Coc*Den + Res, one multiplier bit per cycle.
module multiplicador_algoritmico #(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RSTa,
  input  logic            Start,
  input  logic [size-1:0] Coc,
  input  logic [size-1:0] Den,
  input  logic [size-1:0] Res,
  output logic [size-1:0] Num,
  output logic            Ovf,
  output logic            Busy,
  output logic            Done
);
  localparam int CW = $clog2(size + 1);
  typedef enum logic [1:0] {IDLE, OP, FIN} state_t;
  state_t            state_q, state_d;
  logic [size-1:0]   mr_q, mr_d, num_q, num_d;
  logic [2*size-1:0] md_q, md_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      state_q <= IDLE;
      mr_q    <= '0;
      md_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mr_q    <= mr_d;
      md_q    <= md_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
    end
  end
  // Results are captured from the accumulator value that includes the final add.
  always_comb begin
    state_d = state_q;
    mr_d    = mr_q;
    md_d    = md_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = OP;
        mr_d    = Coc;
        md_d    = {{size{1'b0}}, Den};
        acc_d   = {{size{1'b0}}, Res};
        cnt_d   = CW'(size);
      end
      OP: begin
        acc_d = mr_q[0] ? acc_q + md_q : acc_q;
        md_d  = md_q << 1;
        mr_d  = mr_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
          num_d   = acc_d[size-1:0];
          ovf_d   = |acc_d[2*size-1:size];
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign Num  = num_q;
  assign Ovf  = ovf_q;
  assign Busy = (state_q == OP) || (state_q == FIN);
  assign Done = (state_q == FIN);
endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb_multiplicador_algoritmico: timing/result model checked every cycle plus directed literal vectors.
module tb_multiplicador_algoritmico;
  localparam int SIZE = 32;
  logic            CLK = 1'b0;
  logic            RSTa = 1'b1;
  logic            Start = 1'b0;
  logic [SIZE-1:0] Coc = '0, Den = '0, Res = '0;
  logic [SIZE-1:0] Num;
  logic            Ovf, Busy, Done;
  int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  int busy_left = 0;
  logic [2*SIZE-1:0] pend = '0;
  logic [SIZE-1:0]   m_num = '0;
  logic              m_ovf = 1'b0;

  multiplicador_algoritmico #(.size(SIZE)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start(Start), .Coc(Coc), .Den(Den), .Res(Res),
    .Num(Num), .Ovf(Ovf), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: an accepted request occupies size+1 cycles; result appears in the last one.
  always @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      busy_left = 0;
      m_num = '0;
      m_ovf = 1'b0;
    end else if (CLK) begin
      cyc++;
      if (busy_left == 0) begin
        if (Start) begin
          busy_left = SIZE + 1;
          pend = 64'(Coc) * 64'(Den) + 64'(Res);
        end
      end else begin
        busy_left--;
        if (busy_left == 1) begin
          m_num = pend[SIZE-1:0];
          m_ovf = |pend[2*SIZE-1:SIZE];
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", Busy, busy_left > 0);
    chk("done", Done, busy_left == 1);
    chk("num", Num, m_num);
    chk("ovf", Ovf, m_ovf);
    if (Done) done_cnt++;
  end

  task automatic wait_done(inout int n);
    while (!Done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for Done actual=0 expected=1");
    end
  endtask

  task automatic op(input string name, input logic [SIZE-1:0] c, d, r,
                    input logic [SIZE-1:0] en, input logic eo);
    int n;
    Start = 1'b1; Coc = c; Den = d; Res = r;
    @(negedge CLK);
    Start = 1'b0; Coc = $urandom; Den = $urandom; Res = $urandom;
    n = 1;
    wait_done(n);
    chk({name, "_latency"}, n, 33);
    chk({name, "_num"}, Num, en);
    chk({name, "_ovf"}, Ovf, eo);
    @(negedge CLK);
    chk({name, "_idle"}, Busy, 0);
  endtask

  initial begin
    int n, d0, last;
    logic [SIZE-1:0] exp_b2b [3];
    repeat (2) @(negedge CLK);
    chk("rst_num", Num, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Start = 1'b1;
    @(negedge CLK);
    chk("start_in_rst", Busy, 0);
    Start = 1'b0;
    RSTa = 1'b0;
    @(negedge CLK);

    op("basic", 7, 5, 3, 38, 0);
    op("roundtrip", 14, 7, 2, 100, 0);
    op("ovf_pow", 32'h00010000, 32'h00010000, 0, 0, 1);
    op("ovf_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    op("coc0", 0, 123, 77, 77, 0);
    op("den0", 55, 0, 9, 9, 0);

    // Start re-pulsed mid-operation must be ignored.
    d0 = done_cnt;
    Start = 1'b1; Coc = 7; Den = 5; Res = 3;
    @(negedge CLK);
    Start = 1'b0;
    n = 1;
    repeat (9) begin @(negedge CLK); n++; end
    Start = 1'b1; Coc = 100; Den = 100; Res = 100;
    @(negedge CLK);
    n++;
    Start = 1'b0;
    wait_done(n);
    chk("restart_latency", n, 33);
    chk("restart_num", Num, 38);
    repeat (40) @(negedge CLK);
    chk("restart_single_done", done_cnt - d0, 1);

    // Asynchronous abort mid-operation.
    d0 = done_cnt;
    Start = 1'b1; Coc = 1000; Den = 1000; Res = 0;
    @(negedge CLK);
    Start = 1'b0;
    repeat (14) @(negedge CLK);
    #2 RSTa = 1'b1;
    #1;
    chk("abort_num", Num, 0);
    chk("abort_ovf", Ovf, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    RSTa = 1'b0;
    repeat (40) @(negedge CLK);
    chk("abort_no_done", done_cnt - d0, 0);
    op("after_abort", 3, 4, 1, 13, 0);

    // Start held high: back-to-back operations every size+2 cycles.
    exp_b2b[0] = 10; exp_b2b[1] = 20005; exp_b2b[2] = 32'hFFFE0002;
    Coc = 2; Den = 3; Res = 4; Start = 1'b1;
    last = 0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      wait_done(n);
      chk($sformatf("b2b%0d_num", k), Num, exp_b2b[k]);
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), cyc - last, 34);
      last = cyc;
      if (k == 0) begin Coc = 100; Den = 200; Res = 5; end
      if (k == 1) begin Coc = 32'hFFFF; Den = 32'hFFFF; Res = 1; end
      if (k == 2) Start = 1'b0;
      @(negedge CLK);
    end
    repeat (40) @(negedge CLK);
    chk("final_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
